mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, memory address width.
REQ-002 SHALL have parameter DATA_W, default 16, memory data width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port if_req  input  1  instruction-fetch request; held until if_rdy.
REQ-006 SHALL have port if_addr  input  ADDR_W  fetch address (PC).
REQ-007 SHALL have port if_rdata  output  DATA_W  fetched instruction; valid when if_rdy=1.
REQ-008 SHALL have port if_rdy  output  1  one-cycle fetch-complete pulse.
REQ-009 SHALL have port dm_re  input  1  data read request (decoder re_mem); held until dm_rdy.
REQ-010 SHALL have port dm_we  input  1  data write request (decoder we_mem); held until dm_rdy.
REQ-011 SHALL have port dm_addr  input  ADDR_W  data address.
REQ-012 SHALL have port dm_wdata  input  DATA_W  store data.
REQ-013 SHALL have port dm_rdata  output  DATA_W  load data; valid when dm_rdy=1.
REQ-014 SHALL have port dm_rdy  output  1  one-cycle data-complete pulse.
REQ-015 SHALL have port hlt  input  1  halt from decoder.
REQ-016 SHALL have ports mem_en, mem_we (output 1), mem_addr (output ADDR_W) and mem_wdata (output DATA_W): unified single-port memory command.
REQ-017 SHALL have ports mem_rdata (input DATA_W) and mem_rdy (input 1): memory response, rdy high one cycle per completed command.
REQ-018 SHALL have port stall  output  1  freeze PC and pipeline state.
REQ-019 SHALL have port halted  output  1  arbiter in HALTED state.

Function
REQ-020 SHALL implement FSM states IDLE, FETCH, DATA, HALTED.
REQ-021 In IDLE with hlt=1 and no data request: SHALL go to HALTED next cycle; fetch is not granted.
REQ-022 In IDLE with exactly one requester active: SHALL grant it next cycle (FETCH or DATA).
REQ-023 In IDLE with both active: SHALL grant the one not granted last (round-robin); after reset last_grant=FETCH, so DATA wins first.
REQ-024 On grant: SHALL register the address, write data and write enable; mem_en=1 with a stable command every cycle of FETCH/DATA until mem_rdy.
REQ-025 When mem_rdy=1 in FETCH/DATA: SHALL capture mem_rdata into if_rdata/dm_rdata, pulse if_rdy/dm_rdy the next cycle, and return to IDLE with mem_en=0.
REQ-026 Minimum latency request-to-rdy SHALL be 3 cycles (grant, memory response with mem_rdy same cycle, rdy pulse); one idle cycle separates back-to-back grants.
REQ-027 dm_re=1 and dm_we=1 together SHALL be a write; the read is ignored.
REQ-028 mem_we SHALL be 1 only in DATA for a write; mem_rdy outside FETCH/DATA SHALL be ignored.
REQ-029 A request dropped mid-transaction SHALL not abort it; the rdy pulse still issues.
REQ-030 hlt asserted during FETCH/DATA SHALL let the transaction complete, then take effect from IDLE.
REQ-031 HALTED SHALL be exited only by rst; all requests ignored; halted=1.
REQ-032 stall SHALL be combinational: (if_req & ~if_rdy) | ((dm_re|dm_we) & ~dm_rdy), forced 0 in HALTED.
REQ-033 if_rdata/dm_rdata SHALL hold their last captured value between pulses.

Reset
REQ-034 rst=1 SHALL asynchronously force: state=IDLE, last_grant=FETCH, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, if_rdy=0, dm_rdy=0, if_rdata=0, dm_rdata=0, halted=0.
REQ-035 Reset mid-transaction SHALL discard the transaction; no rdy pulse follows, and a late mem_rdy SHALL be ignored.

Structure
REQ-036 A shared package mem_arb_pkg SHALL hold the state encoding (2 bits) and the ADDR_W/DATA_W defaults.
REQ-037 SHALL be one flat module with no sub-module; grant logic and FSM live together.

Verification
REQ-038 Fetch only: if_req=1, if_addr=0x0010, mem returns 0xB1F0 with rdy one cycle after mem_en -> mem_addr=0x0010, if_rdata=0xB1F0, if_rdy one pulse, stall low the cycle after.
REQ-039 Simultaneous after reset: if_addr=0x0004, dm_we=1, dm_addr=0x0100, dm_wdata=0xBEEF -> write (mem_we=1, 0x0100/0xBEEF) granted first, then fetch 0x0004; both rdy pulses seen.
REQ-040 Memory wait states: mem_rdy delayed 5 cycles -> mem_en/mem_addr stable for all 5 cycles, stall high throughout, single dm_rdy.
REQ-041 Halt: hlt=1 during DATA read from 0x0020 returning 0x1234 -> dm_rdata=0x1234, then HALTED, halted=1, later if_req=1 gives no mem_en.
REQ-042 Reset mid-FETCH: rst pulse while mem_en=1 -> outputs at reset values immediately; later mem_rdy=1 produces no if_rdy.
REQ-043 dm_re=dm_we=1 at 0x0030 with data 0x00FF -> mem_we=1 and dm_rdy pulses once.

Source files
------------

// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arb_pkg
//  Description : Shared types, defaults and grant helper for mem_arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_DATA   = 2'd2,
        ST_HALTED = 2'd3
    } arb_state_t;

    typedef enum logic {
        GNT_FETCH = 1'b0,
        GNT_DATA  = 1'b1
    } grant_t;

    // A pending halt blocks fetch, so data wins whenever fetch cannot be taken.
    function automatic logic data_wins(
        input logic   if_act,
        input logic   dm_act,
        input logic   hold_fetch,
        input grant_t last
    );
        return dm_act && (!if_act || hold_fetch || (last == GNT_FETCH));
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter
//  Description : Round-robin arbiter sharing one single-port memory between
//                instruction fetch and data access, with halt support.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_rdy,
    input  logic              dm_re,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_rdy,
    input  logic              hlt,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_rdy,
    output logic              stall,
    output logic              halted
);

    arb_state_t        r_state;
    arb_state_t        w_state_nxt;
    grant_t            r_last_grant;

    logic              r_mem_en;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [DATA_W-1:0] r_if_rdata;
    logic [DATA_W-1:0] r_dm_rdata;
    logic              r_if_rdy;
    logic              r_dm_rdy;

    logic              w_if_act;
    logic              w_dm_act;
    logic              w_gnt_fetch;
    logic              w_gnt_data;
    logic              w_done;
    logic              w_halted;

    // A requester whose rdy pulse is showing is already satisfied this cycle.
    assign w_if_act = if_req & ~r_if_rdy;
    assign w_dm_act = (dm_re | dm_we) & ~r_dm_rdy;
    assign w_halted = (r_state == ST_HALTED);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_gnt_fetch = 1'b0;
        w_gnt_data  = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (data_wins(w_if_act, w_dm_act, hlt, r_last_grant)) begin
                    w_gnt_data  = 1'b1;
                    w_state_nxt = ST_DATA;
                end else if (hlt) begin
                    w_state_nxt = ST_HALTED;
                end else if (w_if_act) begin
                    w_gnt_fetch = 1'b1;
                    w_state_nxt = ST_FETCH;
                end
            end
            ST_FETCH, ST_DATA: begin
                if (mem_rdy) begin
                    w_done      = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_HALTED: begin
                w_state_nxt = ST_HALTED;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_grant <= GNT_FETCH;
            r_mem_en     <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_if_rdata   <= '0;
            r_dm_rdata   <= '0;
            r_if_rdy     <= 1'b0;
            r_dm_rdy     <= 1'b0;
        end else begin
            r_if_rdy <= 1'b0;
            r_dm_rdy <= 1'b0;
            if (w_gnt_data) begin
                r_last_grant <= GNT_DATA;
                r_mem_en     <= 1'b1;
                r_mem_we     <= dm_we;
                r_mem_addr   <= dm_addr;
                r_mem_wdata  <= dm_wdata;
            end else if (w_gnt_fetch) begin
                r_last_grant <= GNT_FETCH;
                r_mem_en     <= 1'b1;
                r_mem_we     <= 1'b0;
                r_mem_addr   <= if_addr;
                r_mem_wdata  <= '0;
            end else if (w_done) begin
                r_mem_en <= 1'b0;
                r_mem_we <= 1'b0;
                if (r_state == ST_FETCH) begin
                    r_if_rdata <= mem_rdata;
                    r_if_rdy   <= 1'b1;
                end else begin
                    r_dm_rdata <= mem_rdata;
                    r_dm_rdy   <= 1'b1;
                end
            end
        end
    end

    assign mem_en    = r_mem_en;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign if_rdata  = r_if_rdata;
    assign if_rdy    = r_if_rdy;
    assign dm_rdata  = r_dm_rdata;
    assign dm_rdy    = r_dm_rdy;
    assign halted    = w_halted;
    assign stall     = ~w_halted &
                       ((if_req & ~r_if_rdy) | ((dm_re | dm_we) & ~r_dm_rdy));

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_arbiter
//  Description : Self-checking bench for mem_arbiter: directed scenarios then
//                randomized fetch/data traffic against a memory model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int AW = 16;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          if_rdy;
    logic          dm_re;
    logic          dm_we;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic [DW-1:0] dm_rdata;
    logic          dm_rdy;
    logic          hlt;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_rdy;
    logic          stall;
    logic          halted;

    int n_checks;
    int n_fail;

    logic [DW-1:0] mem_model [int];

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk      (clk),
        .rst      (rst),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_rdata (if_rdata),
        .if_rdy   (if_rdy),
        .dm_re    (dm_re),
        .dm_we    (dm_we),
        .dm_addr  (dm_addr),
        .dm_wdata (dm_wdata),
        .dm_rdata (dm_rdata),
        .dm_rdy   (dm_rdy),
        .hlt      (hlt),
        .mem_en   (mem_en),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_rdy  (mem_rdy),
        .stall    (stall),
        .halted   (halted)
    );

    function automatic logic [DW-1:0] model_rd(input int a);
        if (mem_model.exists(a)) return mem_model[a];
        return DW'(a * 4369) ^ 16'h5A5A;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        if_req    = 1'b0;
        if_addr   = '0;
        dm_re     = 1'b0;
        dm_we     = 1'b0;
        dm_addr   = '0;
        dm_wdata  = '0;
        hlt       = 1'b0;
        mem_rdata = '0;
        mem_rdy   = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Waits for a command, checks it stays stable, answers after 'delay' wait cycles.
    task automatic serve(input string tag, input int delay, input logic [DW-1:0] rdata,
                         input logic exp_we, input logic [AW-1:0] exp_addr,
                         input logic [DW-1:0] exp_wdata, output int waited);
        waited = 0;
        while (mem_en !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        for (int i = 0; i <= delay; i++) begin
            chk({tag, "_en"},    32'(mem_en),   32'd1);
            chk({tag, "_we"},    32'(mem_we),   32'(exp_we));
            chk({tag, "_addr"},  32'(mem_addr), 32'(exp_addr));
            if (exp_we) chk({tag, "_wdata"}, 32'(mem_wdata), 32'(exp_wdata));
            chk({tag, "_stall"}, 32'(stall),    32'd1);
            if (i == delay) begin
                mem_rdy   = 1'b1;
                mem_rdata = rdata;
            end
            @(negedge clk);
        end
        mem_rdy   = 1'b0;
        mem_rdata = 16'h5555;
    endtask

    initial begin
        int            waited;
        bit            f_pend, d_pend, f_served, d_served, busy, cur_data, d_wr, last_data;
        int            delay, wcnt, cyc, kind;
        logic [AW-1:0] f_addr, d_addr, cur_addr;
        logic [DW-1:0] d_wdata, f_exp, d_exp;

        n_checks = 0;
        n_fail   = 0;
        f_exp    = '0;
        d_exp    = '0;

        // ---------------- reset values ----------------
        do_reset();
        chk("rst_mem_en",    32'(mem_en),    32'd0);
        chk("rst_mem_we",    32'(mem_we),    32'd0);
        chk("rst_mem_addr",  32'(mem_addr),  32'd0);
        chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        chk("rst_if_rdy",    32'(if_rdy),    32'd0);
        chk("rst_dm_rdy",    32'(dm_rdy),    32'd0);
        chk("rst_if_rdata",  32'(if_rdata),  32'd0);
        chk("rst_dm_rdata",  32'(dm_rdata),  32'd0);
        chk("rst_halted",    32'(halted),    32'd0);
        chk("rst_stall",     32'(stall),     32'd0);

        // ---------------- fetch only ----------------
        if_req  = 1'b1;
        if_addr = 16'h0010;
        serve("fetch", 1, 16'hB1F0, 1'b0, 16'h0010, 16'h0, waited);
        chk("fetch_latency",  32'(waited),   32'd1);
        chk("fetch_if_rdy",   32'(if_rdy),   32'd1);
        chk("fetch_if_rdata", 32'(if_rdata), 32'hB1F0);
        chk("fetch_mem_en_off", 32'(mem_en), 32'd0);
        chk("fetch_stall_rdy", 32'(stall),   32'd0);
        if_req = 1'b0;
        @(negedge clk);
        chk("fetch_rdy_pulse", 32'(if_rdy),   32'd0);
        chk("fetch_stall_low", 32'(stall),    32'd0);
        chk("fetch_hold",      32'(if_rdata), 32'hB1F0);

        // ---------------- simultaneous after reset: data first ----------------
        do_reset();
        if_req   = 1'b1;
        if_addr  = 16'h0004;
        dm_we    = 1'b1;
        dm_addr  = 16'h0100;
        dm_wdata = 16'hBEEF;
        serve("rr_wr", 0, 16'h0000, 1'b1, 16'h0100, 16'hBEEF, waited);
        chk("rr_dm_rdy",    32'(dm_rdy), 32'd1);
        chk("rr_if_not_yet", 32'(if_rdy), 32'd0);
        dm_we = 1'b0;
        serve("rr_fetch", 0, 16'hC0DE, 1'b0, 16'h0004, 16'h0, waited);
        chk("rr_gap",       32'(waited),   32'd1);
        chk("rr_if_rdy",    32'(if_rdy),   32'd1);
        chk("rr_if_rdata",  32'(if_rdata), 32'hC0DE);
        if_req = 1'b0;
        @(negedge clk);

        // ---------------- memory wait states ----------------
        dm_re   = 1'b1;
        dm_addr = 16'h0042;
        serve("wait", 5, 16'h7E57, 1'b0, 16'h0042, 16'h0, waited);
        chk("wait_dm_rdy",   32'(dm_rdy),   32'd1);
        chk("wait_dm_rdata", 32'(dm_rdata), 32'h7E57);
        dm_re = 1'b0;
        @(negedge clk);
        chk("wait_single_rdy", 32'(dm_rdy), 32'd0);

        // ---------------- read+write together is a write ----------------
        dm_re    = 1'b1;
        dm_we    = 1'b1;
        dm_addr  = 16'h0030;
        dm_wdata = 16'h00FF;
        serve("rw", 0, 16'h0000, 1'b1, 16'h0030, 16'h00FF, waited);
        chk("rw_dm_rdy", 32'(dm_rdy), 32'd1);
        dm_re = 1'b0;
        dm_we = 1'b0;
        @(negedge clk);
        chk("rw_single_rdy", 32'(dm_rdy), 32'd0);

        // ---------------- halt during a data read ----------------
        dm_re   = 1'b1;
        dm_addr = 16'h0020;
        @(negedge clk);
        hlt = 1'b1;
        serve("halt_rd", 1, 16'h1234, 1'b0, 16'h0020, 16'h0, waited);
        chk("halt_dm_rdy",   32'(dm_rdy),   32'd1);
        chk("halt_dm_rdata", 32'(dm_rdata), 32'h1234);
        chk("halt_not_yet",  32'(halted),   32'd0);
        dm_re = 1'b0;
        @(negedge clk);
        chk("halt_halted", 32'(halted), 32'd1);
        if_req  = 1'b1;
        if_addr = 16'h0050;
        for (int i = 0; i < 4; i++) begin
            mem_rdy = (i == 1);
            @(negedge clk);
            chk("halt_no_mem_en", 32'(mem_en), 32'd0);
            chk("halt_stall",     32'(stall),  32'd0);
            chk("halt_no_if_rdy", 32'(if_rdy), 32'd0);
        end
        mem_rdy = 1'b0;
        hlt     = 1'b0;
        @(negedge clk);
        chk("halt_sticky", 32'(halted), 32'd1);

        // ---------------- halt from idle blocks fetch ----------------
        do_reset();
        if_req  = 1'b1;
        if_addr = 16'h0060;
        hlt     = 1'b1;
        @(negedge clk);
        chk("idle_halt_no_fetch", 32'(mem_en), 32'd0);
        chk("idle_halt_halted",   32'(halted), 32'd1);

        // ---------------- reset mid-fetch ----------------
        do_reset();
        chk("rst2_halted_clear", 32'(halted), 32'd0);
        if_req  = 1'b1;
        if_addr = 16'h0080;
        @(negedge clk);
        chk("midrst_mem_en", 32'(mem_en), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("midrst_async_en",   32'(mem_en),   32'd0);
        chk("midrst_async_addr", 32'(mem_addr), 32'd0);
        if_req = 1'b0;
        @(negedge clk);
        rst       = 1'b0;
        mem_rdy   = 1'b1;
        mem_rdata = 16'hDEAD;
        @(negedge clk);
        mem_rdy = 1'b0;
        chk("midrst_no_if_rdy", 32'(if_rdy),   32'd0);
        chk("midrst_if_rdata",  32'(if_rdata), 32'd0);
        chk("midrst_idle_en",   32'(mem_en),   32'd0);
        @(negedge clk);
        chk("midrst_no_if_rdy2", 32'(if_rdy), 32'd0);

        // ---------------- randomized traffic ----------------
        do_reset();
        last_data = 1'b0;
        for (int it = 0; it < 60; it++) begin
            kind     = int'($urandom_range(0, 3));
            d_wr     = ($urandom_range(0, 1) == 1);
            f_addr   = AW'($urandom_range(0, 15));
            d_addr   = AW'($urandom_range(0, 15));
            d_wdata  = DW'($urandom);
            f_pend   = (kind == 0) || (kind == 3);
            d_pend   = (kind != 0);
            f_served = 1'b0;
            d_served = 1'b0;
            busy     = 1'b0;
            cur_data = 1'b0;
            cur_addr = '0;
            cyc      = 0;
            wcnt     = 0;
            delay    = 0;
            if_req   = f_pend;
            if_addr  = f_addr;
            dm_we    = d_pend && d_wr;
            dm_re    = d_pend && (!d_wr || ($urandom_range(0, 1) == 1));
            dm_addr  = d_addr;
            dm_wdata = d_wdata;
            while ((f_pend || d_pend) && cyc < 200) begin
                @(negedge clk);
                cyc++;
                mem_rdy = 1'b0;
                if (if_rdy === 1'b1) begin
                    chk("rand_if_rdy_legal", 32'(f_pend && f_served), 32'd1);
                    chk("rand_if_rdata", 32'(if_rdata), 32'(f_exp));
                    f_pend = 1'b0;
                    if_req = 1'b0;
                end
                if (dm_rdy === 1'b1) begin
                    chk("rand_dm_rdy_legal", 32'(d_pend && d_served), 32'd1);
                    if (!d_wr) chk("rand_dm_rdata", 32'(dm_rdata), 32'(d_exp));
                    d_pend = 1'b0;
                    dm_re  = 1'b0;
                    dm_we  = 1'b0;
                end
                if (mem_en === 1'b1) begin
                    if (!busy) begin
                        chk("rand_cmd_expected",
                            32'((d_pend && !d_served) || (f_pend && !f_served)), 32'd1);
                        // Both waiting: the one not served last goes first.
                        cur_data  = (d_pend && !d_served) &&
                                    (!(f_pend && !f_served) || !last_data);
                        cur_addr  = cur_data ? d_addr : f_addr;
                        last_data = cur_data;
                        busy      = 1'b1;
                        wcnt      = 0;
                        delay     = int'($urandom_range(0, 3));
                    end
                    chk("rand_addr", 32'(mem_addr), 32'(cur_addr));
                    chk("rand_we",   32'(mem_we),   32'(cur_data && d_wr));
                    if (cur_data && d_wr) chk("rand_wdata", 32'(mem_wdata), 32'(d_wdata));
                    if (wcnt == delay) begin
                        mem_rdy = 1'b1;
                        busy    = 1'b0;
                        if (cur_data) begin
                            d_served = 1'b1;
                            if (d_wr) begin
                                mem_model[int'(d_addr)] = d_wdata;
                                mem_rdata = DW'($urandom);
                            end else begin
                                d_exp     = model_rd(int'(d_addr));
                                mem_rdata = d_exp;
                            end
                        end else begin
                            f_served  = 1'b1;
                            f_exp     = model_rd(int'(f_addr));
                            mem_rdata = f_exp;
                        end
                    end else begin
                        wcnt++;
                    end
                end else if (busy) begin
                    chk("rand_en_dropped", 32'(mem_en), 32'd1);
                end
            end
            chk("rand_complete", 32'({f_pend, d_pend}), 32'd0);
            mem_rdy = 1'b0;
            repeat ($urandom_range(0, 2) + 1) @(negedge clk);
            chk("rand_idle_if_rdy", 32'(if_rdy), 32'd0);
            chk("rand_idle_dm_rdy", 32'(dm_rdy), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
